// File: rtl/key_note_selector_if.sv
// Button and note bus for the key conditioning stage.
// The slave side is the selector; the master side drives the raw keys and observes the result.
interface key_note_selector_if;
  logic [3:0]  keys_n;
  logic [3:0]  key_state;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic        note_valid;
  logic [1:0]  note_idx;
  logic [15:0] note_period;

  modport slave (
    input  keys_n,
    output key_state, key_press, key_release, note_valid, note_idx, note_period
  );
  modport master (
    output keys_n,
    input  key_state, key_press, key_release, note_valid, note_idx, note_period
  );
endinterface

// File: rtl/key_note_selector.sv
// Debounces four active-low buttons and resolves them to one monophonic note
// (last pressed wins) with the matching tone divide value.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 160000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel
);
  localparam logic [17:0] CNT_MAX = 18'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_ff;
  logic        sync;
  logic [17:0] cnt;

  assign sync = ~sync_ff[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= 2'b11;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], key_n};
      press   <= 1'b0;
      rel     <= 1'b0;
      // any cycle agreeing with the accepted level restarts the count
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync;
        cnt   <= '0;
        press <= sync;
        rel   <= ~sync;
      end else begin
        cnt <= cnt + 18'd1;
      end
    end
  end
endmodule

module key_note_selector #(
  parameter int          DEBOUNCE_CYCLES = 160000,
  parameter logic [15:0] PERIOD_0        = 16'd61157,
  parameter logic [15:0] PERIOD_1        = 16'd54484,
  parameter logic [15:0] PERIOD_2        = 16'd48540,
  parameter logic [15:0] PERIOD_3        = 16'd40816
) (
  input  logic               CLK,
  input  logic               RST,
  key_note_selector_if.slave bus
);
  typedef enum logic {IDLE, HOLD} sel_state_t;

  logic [3:0]  key_state, key_press, key_release;
  sel_state_t  state, next_state;
  logic [1:0]  last_idx, next_idx;
  logic [15:0] note_period;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (CLK),
      .rst   (RST),
      .key_n (bus.keys_n[i]),
      .level (key_state[i]),
      .press (key_press[i]),
      .rel   (key_release[i])
    );
  end

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [15:0] period_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return PERIOD_0;
      2'd1:    return PERIOD_1;
      2'd2:    return PERIOD_2;
      default: return PERIOD_3;
    endcase
  endfunction

  // press beats release; a dropped current key falls back to the lowest still held
  always_comb begin
    next_state = state;
    next_idx   = last_idx;
    if (|key_press) begin
      next_state = HOLD;
      next_idx   = lowest(key_press);
    end else if (state == HOLD) begin
      if (~|key_state)
        next_state = IDLE;
      else if (!key_state[last_idx])
        next_idx = lowest(key_state);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      last_idx    <= 2'd0;
      note_period <= 16'd0;
    end else begin
      state       <= next_state;
      last_idx    <= next_idx;
      note_period <= (next_state == HOLD) ? period_of(next_idx) : 16'd0;
    end
  end

  assign bus.key_state   = key_state;
  assign bus.key_press   = key_press;
  assign bus.key_release = key_release;
  assign bus.note_valid  = (state == HOLD);
  assign bus.note_idx    = last_idx;
  assign bus.note_period = note_period;
endmodule

// File: tb/tb_key_note_selector.sv
// Directed bench for key_note_selector with a short debounce window (8 cycles).
module tb_key_note_selector;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  key_note_selector_if bus();

  key_note_selector #(.DEBOUNCE_CYCLES(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_note(input string tag, input logic v, input logic [1:0] idx, input logic [15:0] per);
    chk({tag, "_valid"},  32'(bus.note_valid),  32'(v));
    chk({tag, "_idx"},    32'(bus.note_idx),    32'(idx));
    chk({tag, "_period"}, 32'(bus.note_period), 32'(per));
  endtask

  initial begin
    bus.keys_n = 4'hF;
    tick(3);
    RST = 1'b0;
    chk("rst_state", 32'(bus.key_state), 0);
    chk("rst_pulses", 32'({bus.key_press, bus.key_release}), 0);
    chk_note("rst", 1'b0, 2'd0, 16'd0);

    // clean press of key 1: key_state at cycle 10, note at cycle 11
    bus.keys_n = 4'b1101;
    tick(9);
    chk("k1_pre_state", 32'(bus.key_state), 0);
    tick();
    chk("k1_state", 32'(bus.key_state), 32'h2);
    chk("k1_press", 32'(bus.key_press), 32'h2);
    chk("k1_valid_lag", 32'(bus.note_valid), 0);
    tick();
    chk("k1_press_gone", 32'(bus.key_press), 0);
    chk_note("k1", 1'b1, 2'd1, 16'd54484);

    bus.keys_n = 4'hF;
    tick(10);
    chk("k1_release", 32'(bus.key_release), 32'h2);
    chk("k1_rel_press", 32'(bus.key_press), 0);
    tick();
    chk_note("k1_off", 1'b0, 2'd1, 16'd0);
    tick(2);

    // bounce on key 0: runs of 3 never reach the 8-cycle window
    for (int t = 0; t < 30; t++) begin
      bus.keys_n = {3'b111, logic'(((t / 3) % 2) != 0)};
      tick();
      chk("bounce", 32'({bus.key_state, bus.key_press, bus.key_release, bus.note_valid}), 0);
    end
    bus.keys_n = 4'hF;
    for (int t = 0; t < 12; t++) begin
      tick();
      chk("bounce_tail", 32'({bus.key_state, bus.key_press, bus.key_release, bus.note_valid}), 0);
    end

    // last pressed wins, then fall back to held key 0
    bus.keys_n = 4'b1110;
    tick(11);
    chk_note("k0", 1'b1, 2'd0, 16'd61157);
    bus.keys_n = 4'b1010;
    tick(10);
    chk("k2_press", 32'(bus.key_press), 32'h4);
    chk("k2_state", 32'(bus.key_state), 32'h5);
    tick();
    chk_note("k2", 1'b1, 2'd2, 16'd48540);
    bus.keys_n = 4'b1110;
    tick(10);
    chk("k2_release", 32'(bus.key_release), 32'h4);
    tick();
    chk_note("k0_back", 1'b1, 2'd0, 16'd61157);
    bus.keys_n = 4'hF;
    tick(11);
    chk_note("k0_off", 1'b0, 2'd0, 16'd0);

    // simultaneous 3 and 1 from idle
    bus.keys_n = 4'b0101;
    tick(10);
    chk("k31_press", 32'(bus.key_press), 32'hA);
    tick();
    chk_note("k31", 1'b1, 2'd1, 16'd54484);
    bus.keys_n = 4'b0111;
    tick(11);
    chk_note("k3", 1'b1, 2'd3, 16'd40816);
    bus.keys_n = 4'hF;
    tick(11);
    chk_note("k3_off", 1'b0, 2'd3, 16'd0);

    // reset while key 2 held
    bus.keys_n = 4'b1011;
    tick(11);
    chk_note("k2_hold", 1'b1, 2'd2, 16'd48540);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_state", 32'({bus.key_state, bus.key_press, bus.key_release}), 0);
    chk_note("mid_rst", 1'b0, 2'd0, 16'd0);
    tick(9);
    chk("rearm_pre", 32'(bus.key_press), 0);
    tick();
    chk("rearm_press", 32'(bus.key_press), 32'h4);
    tick();
    chk_note("rearm", 1'b1, 2'd2, 16'd48540);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_note_selector.md
Name: key_note_selector

Overview:
- Upstream conditioning stage for the tone generator on the TinyFPGA BX (16 MHz CLK).
- Takes the four raw active-low push-buttons and synchronises and debounces each one.
- Resolves the debounced keys to a single monophonic note, last-pressed-wins.
- Emits the selected note index and its full-period divide value, which the tone counter compares against to produce the speaker square wave.

Parameters:
- DEBOUNCE_CYCLES, 160000, consecutive stable cycles required to accept a key change (10 ms at 16 MHz).
- PERIOD_0, 61157, divide value for key 0 (C4).
- PERIOD_1, 54484, divide value for key 1 (D4).
- PERIOD_2, 48540, divide value for key 2 (E4).
- PERIOD_3, 40816, divide value for key 3 (G4).

Ports:
- CLK  input  1  system clock, 16 MHz; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- keys_n  input  4  raw buttons, active-low, asynchronous; bit i = key i.
- key_state  output  4  debounced key levels, active-high (1 = held).
- key_press  output  4  one-cycle pulse per key on debounced press.
- key_release  output  4  one-cycle pulse per key on debounced release.
- note_valid  output  1  high while any debounced key is held.
- note_idx  output  2  index of the selected key.
- note_period  output  16  divide value of the selected key; 0 when note_valid = 0.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Synchroniser: two flops per key on keys_n. Both flops reset to 1 (released). sync_i = ~second flop, so sync_i is active-high.
- Debounce counter, per key:
  - 18-bit counter cnt_i, reset 0.
  - If sync_i == key_state[i]: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: key_state[i] <= sync_i and cnt_i <= 0.
  - Else cnt_i <= cnt_i + 1.
  - Any single-cycle agreement of sync_i with key_state[i] restarts the count (glitch rejection).
  - Counter never wraps.
- Edge pulses: key_press[i] and key_release[i] are registered and asserted for exactly the cycle in which key_state[i] first shows the new value. The two are never both high for the same key.
- Latency: a clean keys_n edge at cycle 0 reaches key_state at cycle 2 + DEBOUNCE_CYCLES.
- Selection state machine: registers last_idx (2 bits) and have_note (1 bit), both reset 0.
  - IDLE (have_note = 0):
    - Any key_press: have_note <= 1, last_idx <= lowest pressed index.
  - HOLD (have_note = 1):
    - New key_press on any key: last_idx <= lowest newly pressed index (last-pressed wins).
    - Else if key_state[last_idx] = 0 and other keys are held: last_idx <= lowest held index.
    - Else if no keys are held: have_note <= 0 (back to IDLE); last_idx is retained.
  - A press and a release in the same cycle: the press takes precedence.
- Outputs, registered from the selection state:
  - note_valid = have_note.
  - note_idx = last_idx.
  - note_period = PERIOD_[last_idx] when have_note = 1, else 0.
  - Outputs lag key_state by exactly 1 cycle.
- Reset mid-operation:
  - All state clears in the cycle RST is sampled high: key_state = 0, pulses = 0, note_valid = 0, note_idx = 0, note_period = 0, counters = 0.
  - Keys held through reset are re-accepted as fresh presses after 2 + DEBOUNCE_CYCLES cycles.
- Output reset values: key_state 0, key_press 0, key_release 0, note_valid 0, note_idx 0, note_period 0.

Test Plan (DEBOUNCE_CYCLES = 8 in simulation):
- Clean press of key 1: drive keys_n = 1101 from cycle 0.
  - key_state = 0010 and key_press = 0010 for one cycle at cycle 10.
  - note_valid = 1, note_idx = 1, note_period = 54484 at cycle 11.
- Bounce: on key 0, toggle keys_n[0] every 3 cycles for 30 cycles, then release.
  - key_state stays 0000, no pulses, note_valid stays 0.
- Last-pressed wins: hold key 0 (note_period = 61157 once settled), then press key 2.
  - note_idx = 2, note_period = 48540 one cycle after key_press[2].
  - Release key 2: falls back to note_idx = 0, note_period = 61157.
- Simultaneous press of keys 3 and 1 from idle: note_idx = 1.
  - Release key 1: note_idx = 3, note_period = 40816.
  - Release key 3: note_valid = 0, note_period = 0.
- Reset mid-hold: assert RST for 1 cycle while key 2 is held.
  - Next cycle: all outputs 0.
  - With key 2 still held, key_press[2] reasserts 10 cycles after RST deasserts, then note_period = 48540.
